// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   Four-entry store queue that sits between the MEM stage and a byte-wide
//   RAM port. Each accepted store {addr, data, size} is drained one byte per
//   granted cycle, lowest byte first, with the byte address wrapping at 2^17.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   st_req/st_addr/      store request from MEM; accepted when st_req and
//   st_data/st_size      st_ready are both high
//   st_ready             queue has a free entry
//   ram_grant            RAM port granted to this block this cycle
//   ram_addr/ram_dout/   byte write to RAM (all zero when not writing)
//   ram_wr
//   sb_empty             queue empty and no write in flight
//   st_done              pulse on the cycle the last byte of an entry is written
//   ld_check/ld_addr     pending load and its base address (4-byte window)
//   ld_conflict          combinational stall request for that load
//
// Configuration
//   STORE_FWD_CHECK_EN   defined: precise address-overlap check for loads.
//                        undefined: any pending store stalls a checked load.
// ---------------------------------------------------------------------------
module store_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_req,
  input  logic [16:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_ready,
  input  logic        ram_grant,
  output logic [16:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  output logic        sb_empty,
  output logic        st_done,
  input  logic        ld_check,
  input  logic [16:0] ld_addr,
  output logic        ld_conflict
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  // Index of the final byte of a store: byte, half, word (11 behaves as word).
  function automatic logic [1:0] last_byte(input logic [1:0] size);
    logic [1:0] r;
    case (size)
      2'b00:   r = 2'd0;
      2'b01:   r = 2'd1;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  // Little-endian byte select.
  function automatic logic [7:0] sel_byte(input logic [31:0] d, input logic [1:0] k);
    logic [7:0] r;
    case (k)
      2'd0:    r = d[7:0];
      2'd1:    r = d[15:8];
      2'd2:    r = d[23:16];
      default: r = d[31:24];
    endcase
    return r;
  endfunction

  // Queue storage and control state
  logic [16:0] addr_q [4];
  logic [31:0] data_q [4];
  logic [1:0]  size_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  state_t      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;

  logic        push_s, pop_s, wr_s, done_s;
  logic [16:0] wr_addr_s;
  logic [7:0]  wr_byte_s;
  logic        empty_s;

  assign push_s = st_req && (count_q != 3'd4);

  // Next-state logic: FSM, byte counter, queue occupancy and RAM write data
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    pop_s     = 1'b0;
    wr_s      = 1'b0;
    done_s    = 1'b0;
    wr_addr_s = 17'd0;
    wr_byte_s = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) begin
          state_d = S_WRITE;
          bcnt_d  = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (ram_grant) begin
          wr_s      = 1'b1;
          // 17-bit add wraps naturally at 2^17
          wr_addr_s = addr_q[rd_ptr_q] + {15'd0, bcnt_q};
          wr_byte_s = sel_byte(data_q[rd_ptr_q], bcnt_q);
          if (bcnt_q == last_byte(size_q[rd_ptr_q])) begin
            pop_s  = 1'b1;
            done_s = 1'b1;
            bcnt_d = 2'd0;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end else begin
          bcnt_d = bcnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        bcnt_d  = 2'd0;
      end
    endcase

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    // After a pop, continue straight into the next entry (a same-edge push
    // counts) so there is no bubble between entries.
    if (pop_s) begin
      state_d = (count_d != 3'd0) ? S_WRITE : S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bcnt_q   <= 2'd0;
      count_q  <= 3'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      count_q <= count_d;
      if (push_s) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + 2'd1;
    end
  end

  // Entry storage; validity is tracked solely by count/pointers
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      addr_q[wr_ptr_q] <= st_addr;
      data_q[wr_ptr_q] <= st_data;
      size_q[wr_ptr_q] <= st_size;
    end
  end

  assign empty_s = (count_q == 3'd0) && (state_q == S_IDLE);

  // Outputs are forced to their idle values while reset is held
  assign st_ready = rst || (count_q != 3'd4);
  assign sb_empty = rst || empty_s;
  assign ram_wr   = !rst && wr_s;
  assign ram_addr = rst ? 17'd0 : wr_addr_s;
  assign ram_dout = rst ? 8'd0 : wr_byte_s;
  assign st_done  = !rst && done_s;

`ifdef STORE_FWD_CHECK_EN
  logic hit_s;

  // Overlap check: any byte of any valid entry inside [ld_addr, ld_addr+3]
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0]  idx;
      idx = rd_ptr_q + 2'(i);
      if (3'(i) < count_q) begin
        for (int j = 0; j < 4; j++) begin
          logic [16:0] diff;
          diff = addr_q[idx] + 17'(j) - ld_addr;
          if ((2'(j) <= last_byte(size_q[idx])) && (diff < 17'd4)) begin
            hit_s = 1'b1;
          end else begin
            hit_s = hit_s;
          end
        end
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign ld_conflict = !rst && ld_check && hit_s;
`else
  logic unused_ld_addr_s;
  assign unused_ld_addr_s = ^ld_addr;
  assign ld_conflict      = !rst && ld_check && !empty_s;
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_req;
  logic [16:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_ready;
  logic        ram_grant;
  logic [16:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic        sb_empty;
  logic        st_done;
  logic        ld_check;
  logic [16:0] ld_addr;
  logic        ld_conflict;

  int errors = 0;
  int checks = 0;

  store_buffer dut (
    .clk(clk), .rst(rst),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_ready(st_ready), .ram_grant(ram_grant),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr),
    .sb_empty(sb_empty), .st_done(st_done),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_conflict(ld_conflict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input string tag, input logic [16:0] a, input logic [7:0] d, input logic done);
    chk({tag, ".wr"},   {31'd0, ram_wr}, 32'd1);
    chk({tag, ".addr"}, {15'd0, ram_addr}, {15'd0, a});
    chk({tag, ".dout"}, {24'd0, ram_dout}, {24'd0, d});
    chk({tag, ".done"}, {31'd0, st_done}, {31'd0, done});
  endtask

  task automatic exp_nowr(input string tag);
    chk({tag, ".wr"},   {31'd0, ram_wr}, 32'd0);
    chk({tag, ".addr"}, {15'd0, ram_addr}, 32'd0);
    chk({tag, ".dout"}, {24'd0, ram_dout}, 32'd0);
  endtask

  task automatic set_st(input logic req, input logic [16:0] a, input logic [31:0] d, input logic [1:0] s);
    st_req  = req;
    st_addr = a;
    st_data = d;
    st_size = s;
  endtask

  logic [16:0] q_addr [11];
  logic [7:0]  q_byte [11];
  logic        q_done [11];

  initial begin
    rst = 1'b1; ram_grant = 1'b0; ld_check = 1'b1; ld_addr = 17'd0;
    set_st(1'b0, 17'd0, 32'd0, 2'b00);

    // ---- reset state
    tick(); tick();
    chk("rst.ready", {31'd0, st_ready}, 32'd1);
    exp_nowr("rst");
    chk("rst.done",  {31'd0, st_done}, 32'd0);
    chk("rst.empty", {31'd0, sb_empty}, 32'd1);
    chk("rst.ldc",   {31'd0, ld_conflict}, 32'd0);
    rst = 1'b0; ld_check = 1'b0;
    tick();
    chk("post_rst.empty", {31'd0, sb_empty}, 32'd1);
    exp_nowr("post_rst");

    // ---- single word store, grant held high
    ram_grant = 1'b1;
    set_st(1'b1, 17'h00100, 32'h11223344, 2'b10);
    tick();                                   // accepted
    st_req = 1'b0; #1;
    chk("sw.empty_after_push", {31'd0, sb_empty}, 32'd0);
    exp_nowr("sw.idle_cycle");
    tick();                                   // now in WRITE
    exp_wr("sw.b0", 17'h00100, 8'h44, 1'b0); tick();
    exp_wr("sw.b1", 17'h00101, 8'h33, 1'b0); tick();
    exp_wr("sw.b2", 17'h00102, 8'h22, 1'b0); tick();
    exp_wr("sw.b3", 17'h00103, 8'h11, 1'b1); tick();
    exp_nowr("sw.after");
    chk("sw.empty", {31'd0, sb_empty}, 32'd1);

    // ---- fill the queue with grant low, then drain
    ram_grant = 1'b0;
    set_st(1'b1, 17'h00200, 32'h000000AA, 2'b00); tick();
    set_st(1'b1, 17'h00300, 32'h0000BBCC, 2'b01); tick();
    set_st(1'b1, 17'h00400, 32'hDDEEFF01, 2'b10); tick();
    exp_nowr("fill.nogrant");
    set_st(1'b1, 17'h00500, 32'h55667788, 2'b11); tick();
    st_req = 1'b0; #1;
    chk("fill.ready_full", {31'd0, st_ready}, 32'd0);
    q_addr = '{17'h200, 17'h300, 17'h301, 17'h400, 17'h401, 17'h402, 17'h403,
               17'h500, 17'h501, 17'h502, 17'h503};
    q_byte = '{8'hAA, 8'hCC, 8'hBB, 8'h01, 8'hFF, 8'hEE, 8'hDD,
               8'h88, 8'h77, 8'h66, 8'h55};
    q_done = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ram_grant = 1'b1; #1;
    chk("fill.ready_before_pop", {31'd0, st_ready}, 32'd0);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      exp_wr($sformatf("fill.b%0d", i), q_addr[i], q_byte[i], q_done[i]);
      if (i == 1) chk("fill.ready_after_pop", {31'd0, st_ready}, 32'd1);
    end
    tick();
    exp_nowr("fill.after");
    chk("fill.empty", {31'd0, sb_empty}, 32'd1);

    // ---- halfword at top of address space, grant 1,0,1
    ram_grant = 1'b0;
    set_st(1'b1, 17'h1FFFF, 32'h0000ABCD, 2'b01); tick();
    st_req = 1'b0; tick();
    ram_grant = 1'b1; #1;
    exp_wr("wrap.b0", 17'h1FFFF, 8'hCD, 1'b0); tick();
    ram_grant = 1'b0; #1;
    exp_nowr("wrap.gap"); tick();
    ram_grant = 1'b1; #1;
    exp_wr("wrap.b1", 17'h00000, 8'hAB, 1'b1); tick();
    exp_nowr("wrap.after");
    chk("wrap.empty", {31'd0, sb_empty}, 32'd1);

    // ---- load conflict check against a pending byte store at 0x50
    ram_grant = 1'b0;
    set_st(1'b1, 17'h00050, 32'h0000005A, 2'b00); tick();
    st_req = 1'b0;
    ld_check = 1'b1; ld_addr = 17'h0004E; #1;
    chk("ldc.overlap", {31'd0, ld_conflict}, 32'd1);
    ld_addr = 17'h00060; #1;
`ifdef STORE_FWD_CHECK_EN
    chk("ldc.disjoint", {31'd0, ld_conflict}, 32'd0);
`else
    chk("ldc.disjoint", {31'd0, ld_conflict}, 32'd1);
`endif
    ld_check = 1'b0; #1;
    chk("ldc.nocheck", {31'd0, ld_conflict}, 32'd0);
    tick();
    ram_grant = 1'b1; #1;
    exp_wr("ldc.drain", 17'h00050, 8'h5A, 1'b1); tick();
    ram_grant = 1'b0; ld_check = 1'b1; ld_addr = 17'h0004E; #1;
    chk("ldc.empty_noconf", {31'd0, ld_conflict}, 32'd0);
    ld_check = 1'b0;

    // ---- reset in the middle of a word store
    ram_grant = 1'b1;
    set_st(1'b1, 17'h00600, 32'hCAFEF00D, 2'b10); tick();
    st_req = 1'b0; tick();
    exp_wr("mid.b0", 17'h00600, 8'h0D, 1'b0); tick();
    exp_wr("mid.b1", 17'h00601, 8'hF0, 1'b0); tick();
    rst = 1'b1; #1;
    exp_nowr("mid.during_rst");
    chk("mid.ready_rst", {31'd0, st_ready}, 32'd1);
    tick();
    rst = 1'b0; #1;
    exp_nowr("mid.after_rst");
    chk("mid.empty", {31'd0, sb_empty}, 32'd1);
    chk("mid.ready", {31'd0, st_ready}, 32'd1);
    tick();
    exp_nowr("mid.no_resume");
    chk("mid.empty2", {31'd0, sb_empty}, 32'd1);

    // ---- push and pop on the same edge at count 2
    ram_grant = 1'b0;
    set_st(1'b1, 17'h00700, 32'h00000001, 2'b00); tick();
    set_st(1'b1, 17'h00701, 32'h00000002, 2'b00); tick();
    set_st(1'b1, 17'h00702, 32'h00000003, 2'b00);
    ram_grant = 1'b1; #1;
    exp_wr("pp.a", 17'h00700, 8'h01, 1'b1); tick();   // pop A, push C
    ram_grant = 1'b0;
    set_st(1'b1, 17'h00703, 32'h00000004, 2'b00); tick();
    st_req = 1'b0; #1;
    chk("pp.ready_cnt3", {31'd0, st_ready}, 32'd1);
    set_st(1'b1, 17'h00704, 32'h00000005, 2'b00); tick();
    st_req = 1'b0; #1;
    chk("pp.ready_cnt4", {31'd0, st_ready}, 32'd0);
    ram_grant = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      exp_wr($sformatf("pp.drain%0d", i), 17'h00701 + 17'(i), 8'(i + 2), 1'b1);
    end
    tick();
    chk("pp.empty", {31'd0, sb_empty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
